pulse_integration_ctrl: RTL and testbench
=========================================

Name: pulse_integration_ctrl

Overview:
Multi-pulse receive back end that sits after the pulse-compression stage on the fast ADC clock domain. It generates the decimated sample clock-enable and the per-PRI start strobe. It non-coherently integrates |pc|² over NUM_PULSES pulses for RANGE_BINS range bins and emits one integrated value per bin on the last pulse of a frame. Pulse count, PRI length, range window and decimation are all parameters.

Parameters:
IN_W, 73, width of the unsigned |pc|² input.
ACC_W, 77, accumulator/output width. Must be ≥ IN_W+clog2(NUM_PULSES); values below that bound are legal but rely on saturation.
DECIM, 16, clk cycles per sample_ce pulse (≥2).
PRI_LEN, 200, decimated samples per PRI.
RANGE_BINS, 128, samples integrated at the start of each PRI (1..PRI_LEN).
NUM_PULSES, 10, pulses per frame (≥1).

Ports:
clk  in  1  fast clock.
rst  in  1  synchronous, active-low reset.
start  in  1  one-cycle frame request.
in_valid  in  1  qualifies in_data, one per decimated sample.
in_data  in  IN_W  unsigned |pc|² sample.
sample_ce  out  1  one-clk pulse every DECIM cycles.
pri_start  out  1  one-clk pulse at each PRI start.
busy  out  1  frame in progress.
out_valid  out  1  out_bin/out_data valid.
out_bin  out  clog2(RANGE_BINS)  range bin index.
out_data  out  ACC_W  integrated power.
frame_done  out  1  one-clk pulse at end of frame.

Behaviour:
- Reset (rst=0): all outputs 0; divider, sample index, pulse index and FSM cleared. Accumulator RAM contents are don't-care because pulse 0 overwrites them.
- Divider: free-running whenever rst=1, independent of the FSM.
  - Counts 0..DECIM-1.
  - sample_ce is registered high in the cycle after the counter equals DECIM-1, so the first pulse comes DECIM cycles after rst rises.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_valid is ignored.
  - start=1 → RUN, pulse_idx=0, sample_idx=0.
  - pri_start and busy are high on the next cycle.
- RUN:
  - Each in_valid advances sample_idx.
  - Bins: sample_idx<RANGE_BINS is bin k=sample_idx; other samples are counted but not stored.
  - When sample_idx=PRI_LEN-1 with in_valid:
    - If pulse_idx<NUM_PULSES-1: sample_idx←0, pulse_idx++, pri_start high next cycle.
    - Otherwise → DONE.
  - start is ignored while busy.
- Accumulate, for bin k:
  - pulse 0: acc[k]←in_data, zero-extended.
  - later pulses: acc[k]←acc[k]+in_data.
  - The add saturates at 2^ACC_W-1.
  - Read-modify-write is a 2-stage pipeline (RAM read, add/write). Each bin is touched once per PRI, so there is no hazard.
- Output:
  - On the last pulse, the sum (acc[k]+in_data) is written and also presented.
  - out_valid is high exactly 2 clk after the in_valid of that sample, with out_bin=k.
  - With NUM_PULSES=1, out_data=in_data.
  - out_valid pulses exactly RANGE_BINS times per frame, in bin order.
- DONE:
  - Waits for the pipeline to drain (out_valid of the last bin if RANGE_BINS=PRI_LEN).
  - Then frame_done=1 for one cycle, busy=0 in that same cycle, → IDLE.
  - Earliest new start is accepted the cycle after frame_done.
- busy is high from the cycle after start acceptance up to, but not including, the frame_done cycle.
- Simultaneous events:
  - pri_start on the first PRI coincides with busy rising.
  - in_valid in the same cycle as start (IDLE) is not sampled.
- Reset mid-frame: immediate return to IDLE with outputs 0 and no frame_done. The next frame is independent of partial data.

Test Plan:
- Default params, rst released at cycle 0 → sample_ce high at cycles 16, 32, 48…, width 1; no other outputs toggle without start.
- DECIM=4, PRI_LEN=6, RANGE_BINS=4, NUM_PULSES=3; start, then in_data=5 on every in_valid → pri_start ×3 spaced 6 samples apart; out_bin 0..3 each with out_data=15; frame_done once after the 18th sample; busy low afterwards.
- Same params, in_data=10p+k for bins (p = pulse, k = bin), 99 on non-bin samples → out_data 30, 33, 36, 39; out_valid exactly 2 clk after the corresponding in_valid.
- IN_W=8, ACC_W=9, NUM_PULSES=3, in_data=255 on all samples → out_data=511 (saturated) for every bin.
- Assert rst=0 after pulse 1 of a frame, release, start a new frame with in_data=1 → no frame_done from the aborted frame; new outputs all equal 3.
- start pulsed mid-frame and in_valid driven while IDLE → no effect: pulse count, outputs and frame_done timing are identical to a clean run.

Source files
------------

// File: rtl/pulse_integration_ctrl.sv
// Multi-pulse non-coherent integrator: decimation strobe, PRI sequencing and
// per-bin |pc|^2 accumulation through a saturating two-stage read-modify-write.
module pulse_integration_ctrl #(
    parameter int unsigned IN_W       = 73,
    parameter int unsigned ACC_W      = 77,
    parameter int unsigned DECIM      = 16,
    parameter int unsigned PRI_LEN    = 200,
    parameter int unsigned RANGE_BINS = 128,
    parameter int unsigned NUM_PULSES = 10,
    localparam int unsigned BIN_W     = (RANGE_BINS > 1) ? $clog2(RANGE_BINS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             sample_ce,
    output logic             pri_start,
    output logic             busy,
    output logic             out_valid,
    output logic [BIN_W-1:0] out_bin,
    output logic [ACC_W-1:0] out_data,
    output logic             frame_done
);
    localparam int unsigned DIV_W = $clog2(DECIM);
    localparam int unsigned SMP_W = (PRI_LEN > 1) ? $clog2(PRI_LEN) : 1;
    localparam int unsigned PUL_W = (NUM_PULSES > 1) ? $clog2(NUM_PULSES) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECIM - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(PRI_LEN - 1);
    localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(NUM_PULSES - 1);
    localparam logic [SMP_W:0]   BIN_LIM  = (SMP_W + 1)'(RANGE_BINS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic             ce_q;
    logic [SMP_W-1:0] smp_q, smp_d;
    logic [PUL_W-1:0] pul_q, pul_d;
    logic             pri_q, pri_d;
    logic             take, is_bin;

    logic             s1_valid_q, s1_first_q, s1_last_q;
    logic [BIN_W-1:0] s1_bin_q;
    logic [IN_W-1:0]  s1_data_q;
    logic [ACC_W-1:0] rd_q, acc_sum;
    logic [SUM_W-1:0] sum_wide;

    logic             ov_q;
    logic [BIN_W-1:0] ob_q;
    logic [ACC_W-1:0] od_q;

    logic [ACC_W-1:0] acc_mem [RANGE_BINS];

    assign take   = (state_q == StRun) && in_valid;
    assign is_bin = {1'b0, smp_q} < BIN_LIM;

    // Divider runs regardless of the FSM so sample_ce keeps its phase across frames.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            ce_q  <= (div_q == DIV_LAST);
        end
    end

    always_comb begin
        state_d    = state_q;
        smp_d      = smp_q;
        pul_d      = pul_q;
        pri_d      = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    smp_d   = '0;
                    pul_d   = '0;
                    pri_d   = 1'b1;
                end
            end
            StRun: begin
                if (in_valid) begin
                    if (smp_q == SMP_LAST) begin
                        if (pul_q != PUL_LAST) begin
                            smp_d = '0;
                            pul_d = pul_q + PUL_W'(1);
                            pri_d = 1'b1;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            StDone: begin
                // Hold off until the final bin has left the output register.
                if (!s1_valid_q && !ov_q) begin
                    frame_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle) && !frame_done;

    always_comb begin
        sum_wide = s1_first_q ? SUM_W'(s1_data_q) : SUM_W'(rd_q) + SUM_W'(s1_data_q);
        acc_sum  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            smp_q      <= '0;
            pul_q      <= '0;
            pri_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bin_q   <= '0;
            s1_data_q  <= '0;
            ov_q       <= 1'b0;
            ob_q       <= '0;
            od_q       <= '0;
        end else begin
            state_q    <= state_d;
            smp_q      <= smp_d;
            pul_q      <= pul_d;
            pri_q      <= pri_d;
            s1_valid_q <= take && is_bin;
            s1_first_q <= (pul_q == '0);
            s1_last_q  <= (pul_q == PUL_LAST);
            s1_bin_q   <= smp_q[BIN_W-1:0];
            s1_data_q  <= in_data;
            ov_q       <= s1_valid_q && s1_last_q;
            if (s1_valid_q && s1_last_q) begin
                ob_q <= s1_bin_q;
                od_q <= acc_sum;
            end
        end
    end

    // Accumulator RAM needs no reset: pulse 0 overwrites every bin.
    always_ff @(posedge clk) begin
        if (take && is_bin) begin
            rd_q <= acc_mem[smp_q[BIN_W-1:0]];
        end
        if (s1_valid_q) begin
            acc_mem[s1_bin_q] <= acc_sum;
        end
    end

    assign sample_ce = ce_q;
    assign pri_start = pri_q;
    assign out_valid = ov_q;
    assign out_bin   = ob_q;
    assign out_data  = od_q;

endmodule

// File: tb/tb_pulse_integration_ctrl.sv
// Directed bench: default-parameter divider check plus small-frame and saturating instances.
module tb_pulse_integration_ctrl;
    localparam int PRI_S = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [15:0] in_data_m = '0;
    logic [7:0]  in_data_s = '0;
    logic        start_def = 1'b0, valid_def = 1'b0;
    logic [72:0] data_def  = '0;

    logic        d_ce, d_pri, d_busy, d_ov, d_fd;
    logic [6:0]  d_bin;
    logic [76:0] d_data;
    logic        m_ce, m_pri, m_busy, m_ov, m_fd;
    logic [1:0]  m_bin;
    logic [19:0] m_data;
    logic        s_ce, s_pri, s_busy, s_ov, s_fd;
    logic [1:0]  s_bin;
    logic [8:0]  s_data;

    pulse_integration_ctrl u_dut_def (
        .clk(clk), .rst(rst), .start(start_def), .in_valid(valid_def), .in_data(data_def),
        .sample_ce(d_ce), .pri_start(d_pri), .busy(d_busy), .out_valid(d_ov),
        .out_bin(d_bin), .out_data(d_data), .frame_done(d_fd)
    );

    pulse_integration_ctrl #(
        .IN_W(16), .ACC_W(20), .DECIM(4), .PRI_LEN(6), .RANGE_BINS(4), .NUM_PULSES(3)
    ) u_dut_main (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data_m),
        .sample_ce(m_ce), .pri_start(m_pri), .busy(m_busy), .out_valid(m_ov),
        .out_bin(m_bin), .out_data(m_data), .frame_done(m_fd)
    );

    pulse_integration_ctrl #(
        .IN_W(8), .ACC_W(9), .DECIM(4), .PRI_LEN(6), .RANGE_BINS(4), .NUM_PULSES(3)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data_s),
        .sample_ce(s_ce), .pri_start(s_pri), .busy(s_busy), .out_valid(s_ov),
        .out_bin(s_bin), .out_data(s_data), .frame_done(s_fd)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int v);
        in_data_m = v[15:0];
        in_data_s = v[7:0];
    endtask

    task automatic sample(input bit sat, output logic ce, output logic pri, output logic bz,
                          output logic ov, output logic fd, output logic [1:0] bin,
                          output logic [63:0] dat);
        if (sat) begin
            ce = s_ce; pri = s_pri; bz = s_busy; ov = s_ov; fd = s_fd; bin = s_bin;
            dat = 64'(s_data);
        end else begin
            ce = m_ce; pri = m_pri; bz = m_busy; ov = m_ov; fd = m_fd; bin = m_bin;
            dat = 64'(m_data);
        end
    endtask

    task automatic run_frame(input string tag, input bit sat, input bit pattern, input int cval,
                             input int exp_base, input int exp_step, input bit disturb,
                             output int fd_lat);
        int smp, pri_cnt, nout, fd_cnt, fd_cyc, last_cyc, busy_gap, busy_post, post, p, k, v;
        int vcyc[4];
        logic ce, pri, bz, ov, fd;
        logic [1:0] bin;
        logic [63:0] dat;
        smp = 0; pri_cnt = 0; nout = 0; fd_cnt = 0; fd_cyc = -1; last_cyc = 0;
        busy_gap = 0; busy_post = 0; post = 0; fd_lat = -1;
        foreach (vcyc[i]) vcyc[i] = 0;
        if (disturb) begin
            // in_valid while idle must be ignored
            for (int i = 0; i < 6; i++) begin
                in_valid = 1'b1;
                drive(1000);
                @(negedge clk);
            end
            sample(sat, ce, pri, bz, ov, fd, bin, dat);
            check_val({tag, "_idle_busy"}, {62'b0, bz, pri}, 64'd0);
        end
        start    = 1'b1;
        in_valid = disturb;
        for (int cyc = 1; cyc <= 250 && post < 10; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            sample(sat, ce, pri, bz, ov, fd, bin, dat);
            if (cyc == 1) begin
                check_val({tag, "_busy_first"}, bz, 1);
                check_val({tag, "_pri_first"}, pri, 1);
            end
            if (pri) begin
                check_val({tag, "_pri_pos"}, smp, pri_cnt * PRI_S);
                pri_cnt++;
            end
            if (ov) begin
                check_val({tag, "_out_bin"}, bin, nout);
                check_val({tag, "_out_data"}, dat, exp_base + nout * exp_step);
                if (nout < 4) check_val({tag, "_out_lat"}, cyc, vcyc[nout] + 2);
                nout++;
            end
            if (fd) begin
                fd_cnt++;
                check_val({tag, "_fd_smp"}, smp, 18);
                check_val({tag, "_fd_nout"}, nout, 4);
                check_val({tag, "_fd_busy"}, bz, 0);
                if (fd_cyc < 0) fd_cyc = cyc;
            end else if (fd_cnt == 0 && !bz) begin
                busy_gap++;
            end else if (fd_cnt > 0 && bz) begin
                busy_post++;
            end
            if (fd_cnt > 0) post++;
            if (disturb && cyc == 20) start = 1'b1;
            if (ce && smp < 18 && fd_cnt == 0) begin
                p = smp / 6;
                k = smp % 6;
                v = pattern ? ((k < 4) ? 10 * p + k : 99) : cval;
                drive(v);
                in_valid = 1'b1;
                if (p == 2 && k < 4) vcyc[k] = cyc;
                last_cyc = cyc;
                smp++;
            end
        end
        check_val({tag, "_pri_cnt"}, pri_cnt, 3);
        check_val({tag, "_out_cnt"}, nout, 4);
        check_val({tag, "_fd_cnt"}, fd_cnt, 1);
        check_val({tag, "_busy_gap"}, busy_gap, 0);
        check_val({tag, "_busy_post"}, busy_post, 0);
        if (fd_cyc >= 0) fd_lat = fd_cyc - last_cyc;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_abort();
        int smp, fd_cnt, ov_cnt, bz_cnt;
        smp = 0; fd_cnt = 0; ov_cnt = 0; bz_cnt = 0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 200 && smp < 12; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
            if (m_ce) begin
                drive(1);
                in_valid = 1'b1;
                smp++;
            end
        end
        check_val("abort_smp", smp, 12);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_val("abort_rst_main", {59'b0, m_ce, m_pri, m_busy, m_ov, m_fd}, 64'd0);
        check_val("abort_rst_sat", {59'b0, s_ce, s_pri, s_busy, s_ov, s_fd}, 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            fd_cnt += int'(m_fd);
            ov_cnt += int'(m_ov);
            bz_cnt += int'(m_busy);
        end
        check_val("abort_no_fd", fd_cnt, 0);
        check_val("abort_no_ov", ov_cnt, 0);
        check_val("abort_no_busy", bz_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_clean, lat_tmp;
        repeat (3) @(negedge clk);
        check_val("rst_def_outs", {58'b0, d_ce, d_pri, d_busy, d_ov, d_fd, |d_bin}, 64'd0);
        check_val("rst_def_data", {63'b0, |d_data}, 64'd0);
        check_val("rst_main_outs", {59'b0, m_ce, m_pri, m_busy, m_ov, m_fd}, 64'd0);
        check_val("rst_main_data", {42'b0, m_bin, m_data}, 64'd0);
        check_val("rst_sat_data", {53'b0, s_bin, s_data}, 64'd0);

        rst = 1'b1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            check_val("def_ce", d_ce, (cyc % 16 == 0));
            check_val("def_quiet", {60'b0, d_pri, d_busy, d_ov, d_fd}, 64'd0);
            check_val("main_ce", m_ce, (cyc % 4 == 0));
        end

        run_frame("const5", 1'b0, 1'b0, 5, 15, 0, 1'b0, lat_tmp);
        run_frame("pattern", 1'b0, 1'b1, 0, 30, 3, 1'b0, lat_clean);
        run_frame("sat", 1'b1, 1'b0, 255, 511, 0, 1'b0, lat_tmp);
        run_abort();
        run_frame("after_abort", 1'b0, 1'b0, 1, 3, 0, 1'b0, lat_tmp);
        run_frame("disturb", 1'b0, 1'b1, 0, 30, 3, 1'b1, lat_tmp);
        check_val("disturb_fd_lat", lat_tmp, lat_clean);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
